// File: rtl/inst_fetch_unit.sv
// -----------------------------------------------------------------------------
// inst_fetch_unit
// Instruction fetch stage for the single-cycle RV32I core. The unit takes the
// core PC, runs one valid/ready read on the instruction-memory bus and returns
// the instruction word with a one-cycle valid pulse. Misaligned PCs, bus error
// responses and response timeouts come back as NOP with an error code.
//
// Optional feature (macro IFU_LAST_HIT_EN): single-entry last-fetch buffer.
// When the macro is defined, an aligned fetch whose PC matches the buffered
// tag returns the buffered word without touching the bus.
//
// Ports:
//   clk, reset        clock, synchronous active-low reset
//   pc_in, fetch_req  fetch address and request from the core (IDLE only)
//   flush             discard the outstanding fetch
//   inst_out          fetched word, held until the next inst_valid
//   inst_valid        one-cycle pulse, fetch_err qualifies it
//   err_code          0 ok, 1 misaligned, 2 bus error, 3 timeout
//   busy              FSM not in IDLE
//   imem_ar*          read address channel (arvalid/araddr out, arready in)
//   imem_r*           read data channel (rvalid/rdata/rresp in, rready out)
// -----------------------------------------------------------------------------
module inst_fetch_unit #(
    parameter int                ADDR_W   = 32,
    parameter int                DATA_W   = 32,
    parameter int                TIMEOUT  = 255,
    parameter logic [DATA_W-1:0] NOP_INST = 32'h00000013
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [ADDR_W-1:0] pc_in,
    input  logic              fetch_req,
    input  logic              flush,
    output logic [DATA_W-1:0] inst_out,
    output logic              inst_valid,
    output logic              fetch_err,
    output logic [1:0]        err_code,
    output logic              busy,
    output logic              imem_arvalid,
    output logic [ADDR_W-1:0] imem_araddr,
    input  logic              imem_arready,
    input  logic              imem_rvalid,
    input  logic [DATA_W-1:0] imem_rdata,
    input  logic [1:0]        imem_rresp,
    output logic              imem_rready
);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_ADDR  = 3'd1;
    localparam logic [2:0] S_DATA  = 3'd2;
    localparam logic [2:0] S_RESP  = 3'd3;
    localparam logic [2:0] S_DRAIN = 3'd4;

    logic [2:0]        r_state;
    logic [7:0]        r_cnt;
    logic              r_drop;
    logic [DATA_W-1:0] r_inst;
    logic              r_vld;
    logic              r_ferr;
    logic [1:0]        r_ecode;
    logic              r_arvalid;
    logic [ADDR_W-1:0] r_araddr;
    logic              r_rready;
    logic              r_busy;

    // A flush in the same cycle as the data beat already counts as a drop.
    logic w_drop;
    logic w_rsp_ok;
    assign w_drop   = r_drop | flush;
    assign w_rsp_ok = (imem_rresp == 2'b00);

`ifdef IFU_LAST_HIT_EN
    logic [ADDR_W-1:0] r_lh_tag;
    logic [DATA_W-1:0] r_lh_data;
    logic              r_lh_vld;
    logic              w_lh_hit;

    // A flush in the hit cycle wins: the buffer is being invalidated.
    assign w_lh_hit = r_lh_vld && (pc_in == r_lh_tag) && !flush;

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_lh_vld  <= 1'b0;
            r_lh_tag  <= '0;
            r_lh_data <= '0;
        end else if (flush) begin
            r_lh_vld <= 1'b0;
        end else if (r_state == S_DATA && imem_rvalid && w_rsp_ok && !r_drop) begin
            r_lh_vld  <= 1'b1;
            r_lh_tag  <= r_araddr;
            r_lh_data <= imem_rdata;
        end
    end
`endif

    // The valid pulse and the returned word are registered on entry to
    // RESP (or the first DRAIN cycle), so they appear together.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state   <= S_IDLE;
            r_cnt     <= '0;
            r_drop    <= 1'b0;
            r_inst    <= NOP_INST;
            r_vld     <= 1'b0;
            r_ferr    <= 1'b0;
            r_ecode   <= 2'd0;
            r_arvalid <= 1'b0;
            r_araddr  <= '0;
            r_rready  <= 1'b0;
            r_busy    <= 1'b0;
        end else begin
            r_vld  <= 1'b0;
            r_ferr <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    r_drop <= 1'b0;
                    if (fetch_req) begin
                        r_busy <= 1'b1;
                        if (pc_in[1:0] != 2'b00) begin
                            r_inst  <= NOP_INST;
                            r_ecode <= 2'd1;
                            r_vld   <= 1'b1;
                            r_ferr  <= 1'b1;
                            r_state <= S_RESP;
`ifdef IFU_LAST_HIT_EN
                        end else if (w_lh_hit) begin
                            r_inst  <= r_lh_data;
                            r_ecode <= 2'd0;
                            r_vld   <= 1'b1;
                            r_state <= S_RESP;
`endif
                        end else begin
                            r_araddr  <= pc_in;
                            r_arvalid <= 1'b1;
                            r_state   <= S_ADDR;
                        end
                    end
                end
                S_ADDR: begin
                    // The request cannot be withdrawn; flush only marks it.
                    if (flush) r_drop <= 1'b1;
                    if (imem_arready) begin
                        r_arvalid <= 1'b0;
                        r_rready  <= 1'b1;
                        r_cnt     <= '0;
                        r_state   <= S_DATA;
                    end
                end
                S_DATA: begin
                    if (flush) r_drop <= 1'b1;
                    if (imem_rvalid) begin
                        r_rready <= 1'b0;
                        r_state  <= S_RESP;
                        if (!w_drop) begin
                            r_inst  <= w_rsp_ok ? imem_rdata : NOP_INST;
                            r_ecode <= w_rsp_ok ? 2'd0 : 2'd2;
                            r_vld   <= 1'b1;
                            r_ferr  <= !w_rsp_ok;
                        end
                    end else if (r_cnt == 8'(TIMEOUT - 1)) begin
                        // rready stays high: the late beat is swallowed in DRAIN.
                        r_state <= S_DRAIN;
                        if (!w_drop) begin
                            r_inst  <= NOP_INST;
                            r_ecode <= 2'd3;
                            r_vld   <= 1'b1;
                            r_ferr  <= 1'b1;
                        end
                    end else begin
                        r_cnt <= r_cnt + 8'd1;
                    end
                end
                S_RESP: begin
                    r_drop  <= 1'b0;
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
                S_DRAIN: begin
                    if (imem_rvalid) begin
                        r_rready <= 1'b0;
                        r_drop   <= 1'b0;
                        r_busy   <= 1'b0;
                        r_state  <= S_IDLE;
                    end
                end
                default: begin
                    r_arvalid <= 1'b0;
                    r_rready  <= 1'b0;
                    r_busy    <= 1'b0;
                    r_state   <= S_IDLE;
                end
            endcase
        end
    end

    assign inst_out     = r_inst;
    assign inst_valid   = r_vld;
    assign fetch_err    = r_ferr;
    assign err_code     = r_ecode;
    assign busy         = r_busy;
    assign imem_arvalid = r_arvalid;
    assign imem_araddr  = r_araddr;
    assign imem_rready  = r_rready;

endmodule

// File: tb/tb_inst_fetch_unit.sv
module tb_inst_fetch_unit;

    localparam int          TMO = 255;
    localparam logic [31:0] NOP = 32'h00000013;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] pc_in;
    logic        fetch_req;
    logic        flush;
    logic [31:0] inst_out;
    logic        inst_valid;
    logic        fetch_err;
    logic [1:0]  err_code;
    logic        busy;
    logic        imem_arvalid;
    logic [31:0] imem_araddr;
    logic        imem_arready;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic [1:0]  imem_rresp;
    logic        imem_rready;

    inst_fetch_unit dut (
        .clk(clk), .reset(reset), .pc_in(pc_in), .fetch_req(fetch_req), .flush(flush),
        .inst_out(inst_out), .inst_valid(inst_valid), .fetch_err(fetch_err),
        .err_code(err_code), .busy(busy), .imem_arvalid(imem_arvalid),
        .imem_araddr(imem_araddr), .imem_arready(imem_arready), .imem_rvalid(imem_rvalid),
        .imem_rdata(imem_rdata), .imem_rresp(imem_rresp), .imem_rready(imem_rready)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_pass = 0;
    int n_tot  = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tot++;
        if (act === exp) n_pass++;
        else $display("FAIL %s at cycle %0d: got %h expected %h", name, cyc, act, exp);
    endtask

    // Expected behaviour of the current fetch, as absolute cycle windows.
    bit          chk_en = 1'b0;
    int          g_ar_lo = -2, g_ar_hi = -2;
    int          g_rr_lo = -2, g_rr_hi = -2;
    int          g_b_lo  = -2, g_b_hi  = -2;
    int          g_pcyc  = -2;
    logic [31:0] g_addr  = '0;
    logic [31:0] g_inst  = '0;
    logic [1:0]  g_code  = '0;
    // Values the core last received; inst_out/err_code must hold them.
    logic [31:0] m_inst  = NOP;
    logic [1:0]  m_code  = 2'd0;
    int          last_pulse = -1;
    // Last-hit buffer model (only consulted when the feature is built in).
    bit          m_hv = 1'b0;
    logic [31:0] m_tag = '0;
    logic [31:0] m_hd = '0;
    logic        pe;

    always @(negedge clk) begin
        if (chk_en) begin
            pe = (cyc == g_pcyc);
            chk("inst_valid", 32'(inst_valid), 32'(pe));
            if (pe) begin
                m_inst = g_inst;
                m_code = g_code;
            end
            chk("inst_out", inst_out, m_inst);
            chk("err_code", 32'(err_code), 32'(m_code));
            chk("fetch_err", 32'(fetch_err), 32'(pe && m_code != 2'd0));
            chk("arvalid", 32'(imem_arvalid), 32'(cyc >= g_ar_lo && cyc <= g_ar_hi));
            if (imem_arvalid) chk("araddr", imem_araddr, g_addr);
            chk("rready", 32'(imem_rready), 32'(cyc >= g_rr_lo && cyc <= g_rr_hi));
            chk("busy", 32'(busy), 32'(cyc >= g_b_lo && cyc <= g_b_hi));
            if (inst_valid) last_pulse = cyc;
        end
    end

    // One fetch. Cycle 0 is the IDLE cycle carrying fetch_req. arready is
    // given ar_dly cycles into ADDR, rvalid r_dly cycles into DATA; r_dly >= TMO
    // means a timeout with the beat arriving late in DRAIN. fc is the relative
    // cycle carrying flush (-1 for none).
    task automatic do_fetch(input logic [31:0] pc, input int ar_dly, input int r_dly,
                            input logic [1:0] resp, input logic [31:0] data,
                            input int fc, output int c0);
        bit mis, hit, bus, to, drop;
        int rv;
        c0  = cyc;
        mis = (pc[1:0] != 2'b00);
`ifdef IFU_LAST_HIT_EN
        hit = !mis && m_hv && (pc == m_tag);
`else
        hit = 1'b0;
`endif
        bus  = !mis && !hit;
        if (!bus) fc = -1;
        to   = bus && (r_dly >= TMO);
        drop = bus && (fc >= 0);
        rv   = -2;
        if (!bus) begin
            g_ar_lo = -2; g_ar_hi = -2; g_rr_lo = -2; g_rr_hi = -2;
            g_b_lo  = c0 + 1; g_b_hi = c0 + 1;
            g_pcyc  = c0 + 1;
            g_inst  = mis ? NOP : m_hd;
            g_code  = mis ? 2'd1 : 2'd0;
        end else begin
            g_addr  = pc;
            g_ar_lo = c0 + 1; g_ar_hi = c0 + 1 + ar_dly;
            g_rr_lo = c0 + 2 + ar_dly;
            rv      = c0 + 2 + ar_dly + r_dly;
            g_rr_hi = rv;
            g_b_lo  = c0 + 1;
            if (to) begin
                g_b_hi = rv;
                g_pcyc = drop ? -2 : c0 + 2 + ar_dly + TMO;
                g_inst = NOP;
                g_code = 2'd3;
            end else begin
                g_b_hi = rv + 1;
                g_pcyc = drop ? -2 : rv + 1;
                g_inst = (resp == 2'b00) ? data : NOP;
                g_code = (resp == 2'b00) ? 2'd0 : 2'd2;
            end
        end
        for (int n = 0; c0 + n <= g_b_hi; n++) begin
            // Requests while busy are noise the unit must ignore.
            fetch_req    = (n == 0) ? 1'b1 : ($urandom_range(0, 3) == 0);
            pc_in        = (n == 0) ? pc : $urandom;
            flush        = (n == fc);
            imem_arready = bus && (c0 + n == g_ar_hi);
            imem_rvalid  = bus && (c0 + n == rv);
            imem_rdata   = imem_rvalid ? data : $urandom;
            imem_rresp   = imem_rvalid ? resp : 2'($urandom);
            @(posedge clk); #1;
        end
        fetch_req = 1'b0; flush = 1'b0; imem_arready = 1'b0; imem_rvalid = 1'b0;
        if (drop) m_hv = 1'b0;
        else if (bus && !to && resp == 2'b00) begin
            m_hv = 1'b1; m_tag = pc; m_hd = data;
        end
    endtask

    task automatic idle(input bit fl);
        pc_in = $urandom;
        flush = fl;
        @(posedge clk); #1;
        flush = 1'b0;
        if (fl) m_hv = 1'b0;
    endtask

    int c0;

    initial begin
        reset = 1'b0; pc_in = '0; fetch_req = 1'b0; flush = 1'b0;
        imem_arready = 1'b0; imem_rvalid = 1'b0; imem_rdata = '0; imem_rresp = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_inst_out", inst_out, 32'h00000013);
        chk("rst_inst_valid", 32'(inst_valid), 32'd0);
        chk("rst_arvalid", 32'(imem_arvalid), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_araddr", imem_araddr, 32'd0);
        chk("rst_rready", 32'(imem_rready), 32'd0);
        chk("rst_err_code", 32'(err_code), 32'd0);
        @(posedge clk); #1;
        reset  = 1'b1;
        chk_en = 1'b1;
        idle(1'b0);

        // Basic fetch: arready in the first ADDR cycle, data in the first DATA cycle.
        do_fetch(32'h80000000, 0, 0, 2'b00, 32'h00100093, -1, c0);
        chk("lat_basic", 32'(last_pulse - c0), 32'd3);
        chk("lit_basic_inst", inst_out, 32'h00100093);

        // Flush in DATA: no pulse, inst_out keeps the previous word.
        do_fetch(32'h80000010, 0, 2, 2'b00, 32'h00000073, 3, c0);
        chk("lit_flush_hold", inst_out, 32'h00100093);
        chk("lit_flush_nopulse", 32'(last_pulse < c0), 32'd1);
        do_fetch(32'h80000010, 1, 1, 2'b00, 32'h00000073, -1, c0);
        chk("lit_after_flush", inst_out, 32'h00000073);

        // Misaligned PC.
        do_fetch(32'h80000002, 0, 0, 2'b00, 32'h11111111, -1, c0);
        chk("lit_mis_inst", inst_out, 32'h00000013);
        chk("lit_mis_code", 32'(err_code), 32'd1);

        // Bus error response.
        do_fetch(32'h80000020, 0, 1, 2'b10, 32'hdeadbeef, -1, c0);
        chk("lit_berr_inst", inst_out, 32'h00000013);
        chk("lit_berr_code", 32'(err_code), 32'd2);

        // Flush coinciding with the data beat.
        do_fetch(32'h80000030, 2, 0, 2'b00, 32'h00500113, 4, c0);

        // Timeout boundaries: last legal cycle, beat in first DRAIN cycle, late beat.
        do_fetch(32'h80000040, 0, TMO - 1, 2'b00, 32'h00200193, -1, c0);
        chk("lit_tmo_edge", inst_out, 32'h00200193);
        do_fetch(32'h80000044, 1, TMO, 2'b00, 32'h12345678, -1, c0);
        chk("lit_tmo_code", 32'(err_code), 32'd3);
        do_fetch(32'h80000048, 0, TMO + 3, 2'b00, 32'h12345678, -1, c0);
        chk("lit_tmo_inst", inst_out, 32'h00000013);

        // Repeat fetch, then flush in IDLE, then the same PC again.
        do_fetch(32'h80000004, 0, 0, 2'b00, 32'h00300213, -1, c0);
        do_fetch(32'h80000004, 0, 1, 2'b00, 32'h00300213, -1, c0);
        idle(1'b1);
        do_fetch(32'h80000004, 1, 0, 2'b00, 32'h00300213, -1, c0);

        for (int i = 0; i < 60; i++) begin
            logic [31:0] pc;
            logic [1:0]  rsp;
            int          ar, rd, fc;
            pc  = 32'h80000000 + 32'(4 * $urandom_range(0, 3));
            if ($urandom_range(0, 9) == 0) pc = pc + 32'($urandom_range(1, 3));
            ar  = $urandom_range(0, 3);
            rd  = $urandom_range(0, 4);
            rsp = ($urandom_range(0, 3) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
            fc  = ($urandom_range(0, 5) == 0) ? $urandom_range(1, 2 + ar + rd) : -1;
            do_fetch(pc, ar, rd, rsp, $urandom, fc, c0);
            if ($urandom_range(0, 3) == 0) idle($urandom_range(0, 4) == 0);
        end

        idle(1'b0);
        idle(1'b0);
        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end

endmodule
